// File: rtl/seg_scan_driver_if.sv
// Display bus between the CPU debug-word selector and the seven-segment
// scan driver.
//   i_data    : 64-bit display word (text mode uses [31:0])
//   disp_mode : 0 = hex text, 1 = raw graphics
//   o_seg     : active-low segments {dp,g,f,e,d,c,b,a}
//   o_sel     : active-low one-hot anode select, bit k = digit k (0 = rightmost)
//   o_frame   : one-cycle pulse when a new frame is latched
// master = word source / display pins consumer, slave = scan driver.
interface seg_scan_driver_if;
  logic [63:0] i_data;
  logic        disp_mode;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  modport master (output i_data, disp_mode, input o_seg, o_sel, o_frame);
  modport slave  (input i_data, disp_mode, output o_seg, o_sel, o_frame);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for the 8-digit common-anode seven-segment display.
// The digit index advances every 2^SCAN_DIV_W clocks; the display word and
// mode are latched only when the scan wraps from digit 7 back to digit 0, so
// a frame never mixes old and new data.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset (blanks the display immediately)
//   bus  : seg_scan_driver_if.slave (i_data, disp_mode in; o_seg, o_sel,
//          o_frame out)
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV_W = 15,
  parameter int unsigned N_DIGITS   = 8
) (
  input logic              clk,
  input logic              rstn,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  logic [SCAN_DIV_W-1:0] r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [63:0]           r_data_q;
  logic                  r_mode_q;
  logic [N_DIGITS-1:0]   r_sel;
  logic [7:0]            r_seg;
  logic                  r_frame;

  logic                  w_tick;
  logic                  w_wrap;
  logic [IDX_W-1:0]      w_next_idx;
  logic [63:0]           w_src_data;
  logic                  w_src_mode;
  logic [3:0]            w_nib;
  logic [7:0]            w_byte;
  logic [7:0]            w_hex;
  logic [7:0]            w_next_seg;
  logic [N_DIGITS-1:0]   w_next_sel;

  assign w_tick     = &r_cnt;
  assign w_wrap     = w_tick && (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_next_idx = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);

  // At the wrap, digit 0 is rendered from the word being latched on this
  // same edge, so the new frame starts with fresh data rather than stale.
  assign w_src_data = w_wrap ? bus.i_data    : r_data_q;
  assign w_src_mode = w_wrap ? bus.disp_mode : r_mode_q;

  always_comb begin
    w_nib  = '0;
    w_byte = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (w_next_idx == IDX_W'(k)) begin
        w_nib  = w_src_data[4*k +: 4];
        w_byte = w_src_data[8*k +: 8];
      end
    end
  end

  // Active-low hex glyphs with dp off.
  always_comb begin
    w_hex = 8'hFF;
    case (w_nib)
      4'h0: w_hex = 8'hC0;
      4'h1: w_hex = 8'hF9;
      4'h2: w_hex = 8'hA4;
      4'h3: w_hex = 8'hB0;
      4'h4: w_hex = 8'h99;
      4'h5: w_hex = 8'h92;
      4'h6: w_hex = 8'h82;
      4'h7: w_hex = 8'hF8;
      4'h8: w_hex = 8'h80;
      4'h9: w_hex = 8'h90;
      4'hA: w_hex = 8'h88;
      4'hB: w_hex = 8'h83;
      4'hC: w_hex = 8'hC6;
      4'hD: w_hex = 8'hA1;
      4'hE: w_hex = 8'h86;
      4'hF: w_hex = 8'h8E;
      default: w_hex = 8'hFF;
    endcase
  end

  assign w_next_seg = w_src_mode ? w_byte : w_hex;
  assign w_next_sel = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << w_next_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data_q <= '0;
      r_mode_q <= 1'b0;
      r_sel    <= '1;
      r_seg    <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + SCAN_DIV_W'(1);
      r_frame <= w_wrap;
      if (w_tick) begin
        r_idx <= w_next_idx;
        r_sel <= w_next_sel;
        r_seg <= w_next_seg;
        if (w_wrap) begin
          r_data_q <= bus.i_data;
          r_mode_q <= bus.disp_mode;
        end
      end
    end
  end

  assign bus.o_seg   = r_seg;
  assign bus.o_sel   = r_sel;
  assign bus.o_frame = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rstn;

  seg_scan_driver_if bus();

  seg_scan_driver #(.SCAN_DIV_W(2), .N_DIGITS(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [7:0] hex_code(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0; 4'h1: c = 8'hF9; 4'h2: c = 8'hA4; 4'h3: c = 8'hB0;
      4'h4: c = 8'h99; 4'h5: c = 8'h92; 4'h6: c = 8'h82; 4'h7: c = 8'hF8;
      4'h8: c = 8'h80; 4'h9: c = 8'h90; 4'hA: c = 8'h88; 4'hB: c = 8'h83;
      4'hC: c = 8'hC6; 4'hD: c = 8'hA1; 4'hE: c = 8'h86; default: c = 8'h8E;
    endcase
    return c;
  endfunction

  // Reference model: derives the expected pins from the number of clocks
  // since reset release and pushes one expectation per clock edge.
  int unsigned m_cyc;
  logic [63:0] m_data;
  logic        m_mode;
  exp_t        m_out;

  always @(posedge clk or negedge rstn) begin
    int unsigned digit;
    if (!rstn) begin
      m_cyc  = 0;
      m_data = '0;
      m_mode = 1'b0;
      m_out  = '{sel: 8'hFF, seg: 8'hFF, frame: 1'b0};
      exp_q.delete();
    end else begin
      m_cyc++;
      m_out.frame = 1'b0;
      if (m_cyc % 4 == 0) begin
        digit = (m_cyc / 4) % 8;
        if (digit == 0) begin
          m_data      = bus.i_data;
          m_mode      = bus.disp_mode;
          m_out.frame = 1'b1;
        end
        m_out.sel = 8'hFF ^ (8'h01 << digit);
        if (m_mode) m_out.seg = m_data[8*digit +: 8];
        else        m_out.seg = hex_code(m_data[4*digit +: 4]);
      end
      exp_q.push_back(m_out);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.o_sel, bus.o_seg, bus.o_frame} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got sel=%h seg=%h frame=%b, expected sel=%h seg=%h frame=%b",
                 $time, bus.o_sel, bus.o_seg, bus.o_frame, e.sel, e.seg, e.frame);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.o_frame !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.o_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_frame_timeout: o_frame=%b after %0d cycles, required 1", tag, bus.o_frame, n);
    end
  endtask

  task automatic test_reset;
    logic [7:0] es, eg;
    rstn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_sel !== 8'hFF || bus.o_seg !== 8'hFF || bus.o_frame !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: sel=%h seg=%h frame=%b, required FF FF 0", bus.o_sel, bus.o_seg, bus.o_frame);
      end
    end
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      es = (i < 4) ? 8'hFF : 8'hFD;
      eg = (i < 4) ? 8'hFF : 8'hC0;
      n_checks++;
      if (bus.o_sel !== es || bus.o_seg !== eg || bus.o_frame !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_cyc%0d: sel=%h seg=%h frame=%b, required %h %h 0",
                 i, bus.o_sel, bus.o_seg, bus.o_frame, es, eg);
      end
    end
  endtask

  task automatic test_text;
    logic [7:0] exp_seg [8];
    exp_seg = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    bus.disp_mode = 1'b0;
    bus.i_data    = 64'hDEAD_BEEF_1234_5678;
    wait_frame("text");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(4);
      n_checks++;
      if (bus.o_sel !== (8'hFF ^ (8'h01 << k)) || bus.o_seg !== exp_seg[k]) begin
        n_fail++;
        $display("FAIL text_digit%0d: sel=%h seg=%h, required %h %h",
                 k, bus.o_sel, bus.o_seg, 8'hFF ^ (8'h01 << k), exp_seg[k]);
      end
    end
  endtask

  task automatic test_graphics;
    logic [7:0] exp_seg [8];
    int d;
    exp_seg = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    bus.disp_mode = 1'b1;
    bus.i_data    = 64'h0102_0408_1020_4080;
    wait_frame("graphics");
    for (int c = 0; c < 32; c++) begin
      if (c > 0) step(1);
      d = c / 4;
      n_checks++;
      if (bus.o_sel !== (8'hFF ^ (8'h01 << d)) || bus.o_seg !== exp_seg[d] || bus.o_frame !== (c == 0)) begin
        n_fail++;
        $display("FAIL graphics_cyc%0d: sel=%h seg=%h frame=%b, required %h %h %b",
                 c, bus.o_sel, bus.o_seg, bus.o_frame, 8'hFF ^ (8'h01 << d), exp_seg[d], (c == 0));
      end
    end
  endtask

  task automatic test_midframe;
    bus.disp_mode = 1'b0;
    bus.i_data    = 64'h0000_0000_1111_1111;
    wait_frame("midframe");
    step(12);
    n_checks++;
    if (bus.o_sel !== 8'hF7 || bus.o_seg !== 8'hF9) begin
      n_fail++;
      $display("FAIL midframe_digit3: sel=%h seg=%h, required F7 F9", bus.o_sel, bus.o_seg);
    end
    bus.i_data = 64'h0000_0000_2222_2222;
    for (int k = 4; k < 8; k++) begin
      step(4);
      n_checks++;
      if (bus.o_sel !== (8'hFF ^ (8'h01 << k)) || bus.o_seg !== 8'hF9) begin
        n_fail++;
        $display("FAIL midframe_old_digit%0d: sel=%h seg=%h, required %h F9",
                 k, bus.o_sel, bus.o_seg, 8'hFF ^ (8'h01 << k));
      end
    end
    step(4);
    n_checks++;
    if (bus.o_frame !== 1'b1 || bus.o_sel !== 8'hFE || bus.o_seg !== 8'hA4) begin
      n_fail++;
      $display("FAIL midframe_new_frame: frame=%b sel=%h seg=%h, required 1 FE A4",
               bus.o_frame, bus.o_sel, bus.o_seg);
    end
  endtask

  task automatic test_async_reset;
    step(20);
    n_checks++;
    if (bus.o_sel !== 8'hDF || bus.o_seg !== 8'hA4) begin
      n_fail++;
      $display("FAIL async_pre_digit5: sel=%h seg=%h, required DF A4", bus.o_sel, bus.o_seg);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.o_sel !== 8'hFF || bus.o_seg !== 8'hFF || bus.o_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL async_blank: sel=%h seg=%h frame=%b, required FF FF 0", bus.o_sel, bus.o_seg, bus.o_frame);
    end
    test_reset();
  endtask

  task automatic test_frame_period;
    int pulses = 0;
    int last   = 0;
    logic prev = 1'b0;
    for (int c = 1; c <= 320; c++) begin
      @(negedge clk);
      if (prev === 1'b1) begin
        n_checks++;
        if (bus.o_frame !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_width at cyc %0d: o_frame=%b, required 0", c, bus.o_frame);
        end
      end
      if (bus.o_frame === 1'b1) begin
        pulses++;
        if (last > 0) begin
          n_checks++;
          if (c - last != 32) begin
            n_fail++;
            $display("FAIL frame_spacing: gap=%0d cycles, required 32", c - last);
          end
        end
        last = c;
      end
      prev = bus.o_frame;
    end
    n_checks++;
    if (pulses != 10) begin
      n_fail++;
      $display("FAIL frame_count: pulses=%0d, required 10", pulses);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn          = 1'b0;
    bus.i_data    = '0;
    bus.disp_mode = 1'b0;
    test_reset();
    test_text();
    test_graphics();
    test_midframe();
    test_async_reset();
    test_frame_period();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
